// File: rtl/alu_pkg.sv
// Shared ALU definitions: default datapath width and the adder flag bundle.
package alu_pkg;

  localparam int ADDSUB_WIDTH_DEFAULT = 64;

  typedef struct packed {
    logic cout;
    logic overflow;
    logic zero;
    logic negative;
  } addsub_flags_t;

endpackage

// File: rtl/adder_subtractor_if.sv
// Operand/result bundle between the ALU front end (master) and the adder/subtractor (slave).
interface adder_subtractor_if #(
  parameter int WIDTH = alu_pkg::ADDSUB_WIDTH_DEFAULT
);
  logic             in_valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             subtract;
  logic             out_valid;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             overflow;
  logic             zero;
  logic             negative;

  modport master (
    output in_valid, A, B, subtract,
    input  out_valid, Sum, Cout, overflow, zero, negative
  );

  modport slave (
    input  in_valid, A, B, subtract,
    output out_valid, Sum, Cout, overflow, zero, negative
  );
endinterface

// File: rtl/adder_subtractor_bit.sv
// One ripple cell: conditionally inverts B so the chain computes A + ~B + 1 when subtracting.
module adder_subtractor_bit (
  input  logic A,
  input  logic B,
  input  logic Cin,
  input  logic subtract,
  output logic Cout,
  output logic Sum
);

  logic b_eff;

  assign b_eff = B ^ subtract;
  assign Sum   = A ^ b_eff ^ Cin;
  assign Cout  = (A & b_eff) | (A & Cin) | (b_eff & Cin);

endmodule

// File: rtl/adder_subtractor.sv
// Registered ripple adder/subtractor with carry, signed overflow and flag outputs.
// Define ADDSUB_FLAGS_EN to compute zero/negative; otherwise they are held at 0.
module adder_subtractor
  import alu_pkg::*;
#(
  parameter int WIDTH = ADDSUB_WIDTH_DEFAULT
) (
  input logic               clk,
  input logic               reset_n,
  adder_subtractor_if.slave bus
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] sum_q;
  addsub_flags_t    flags_d;
  addsub_flags_t    flags_q;
  logic             valid_q;

  assign carry[0] = bus.subtract;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    adder_subtractor_bit u_bit (
      .A        (bus.A[i]),
      .B        (bus.B[i]),
      .Cin      (carry[i]),
      .subtract (bus.subtract),
      .Cout     (carry[i+1]),
      .Sum      (sum_d[i])
    );
  end

  always_comb begin
    flags_d          = '0;
    flags_d.cout     = carry[WIDTH];
    flags_d.overflow = carry[WIDTH] ^ carry[WIDTH-1];
`ifdef ADDSUB_FLAGS_EN
    flags_d.zero     = ~|sum_d;
    flags_d.negative = sum_d[WIDTH-1];
`endif
  end

  // Result registers hold between operations; only out_valid tracks in_valid every cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      flags_q <= '0;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        sum_q   <= sum_d;
        flags_q <= flags_d;
      end
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.Sum       = sum_q;
  assign bus.Cout      = flags_q.cout;
  assign bus.overflow  = flags_q.overflow;
  assign bus.zero      = flags_q.zero;
  assign bus.negative  = flags_q.negative;

endmodule

// File: tb/tb_adder_subtractor.sv
// Self-checking bench for adder_subtractor: arithmetic reference model plus directed literal vectors.
module tb_adder_subtractor;

  localparam int W = 64;

  bit   clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  adder_subtractor_if #(.WIDTH(W)) bus ();

  adder_subtractor #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: plain wide arithmetic, signed overflow from operand/result signs.
  logic [W-1:0] m_sum = '0;
  logic         m_valid = 1'b0, m_cout = 1'b0, m_ovf = 1'b0, m_zero = 1'b0, m_neg = 1'b0;
  logic [W:0]   full;
  logic [W-1:0] res;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_valid <= 1'b0; m_sum <= '0; m_cout <= 1'b0;
      m_ovf <= 1'b0; m_zero <= 1'b0; m_neg <= 1'b0;
    end else begin
      m_valid <= bus.in_valid;
      if (bus.in_valid) begin
        if (bus.subtract) full = {1'b0, bus.A} + {1'b0, ~bus.B} + 1;
        else              full = {1'b0, bus.A} + {1'b0, bus.B};
        res = full[W-1:0];
        m_sum  <= res;
        m_cout <= full[W];
        if (bus.subtract)
          m_ovf <= (bus.A[W-1] != bus.B[W-1]) && (res[W-1] != bus.A[W-1]);
        else
          m_ovf <= (bus.A[W-1] == bus.B[W-1]) && (res[W-1] != bus.A[W-1]);
`ifdef ADDSUB_FLAGS_EN
        m_zero <= (res == 0);
        m_neg  <= res[W-1];
`else
        m_zero <= 1'b0;
        m_neg  <= 1'b0;
`endif
      end
    end
  end

  task automatic chk64(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk1 ("model_out_valid", bus.out_valid, m_valid);
    chk64("model_sum",       bus.Sum,       m_sum);
    chk1 ("model_cout",      bus.Cout,      m_cout);
    chk1 ("model_overflow",  bus.overflow,  m_ovf);
    chk1 ("model_zero",      bus.zero,      m_zero);
    chk1 ("model_negative",  bus.negative,  m_neg);
  end

  // Called just after a falling edge; checks hand-computed results one cycle later.
  task automatic op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic s, input logic [W-1:0] es, input logic ec,
                    input logic eo, input logic ez, input logic en);
    bus.A = a; bus.B = b; bus.subtract = s; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk1 ({name, "_valid"}, bus.out_valid, 1'b1);
    chk64({name, "_sum"},   bus.Sum,       es);
    chk1 ({name, "_cout"},  bus.Cout,      ec);
    chk1 ({name, "_ovf"},   bus.overflow,  eo);
`ifdef ADDSUB_FLAGS_EN
    chk1 ({name, "_zero"},  bus.zero,      ez);
    chk1 ({name, "_neg"},   bus.negative,  en);
`else
    chk1 ({name, "_zero"},  bus.zero,      1'b0);
    chk1 ({name, "_neg"},   bus.negative,  1'b0);
`endif
  endtask

  initial begin
    logic [W-1:0] bb_a [4];
    logic [W-1:0] bb_b [4];
    logic         bb_s [4];
    logic [W-1:0] bb_e [4];

    reset_n = 1'b0;
    bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.subtract = 1'b0;
    repeat (2) @(negedge clk);
    chk1 ("reset_valid", bus.out_valid, 1'b0);
    chk64("reset_sum",   bus.Sum,       '0);
    reset_n = 1'b1;
    @(negedge clk);

    op("zero_add",  64'd0,  64'd0,  1'b0, 64'd0,  1'b0, 1'b0, 1'b1, 1'b0);
    op("add_10_5",  64'd10, 64'd5,  1'b0, 64'd15, 1'b0, 1'b0, 1'b0, 1'b0);
    op("sub_10_5",  64'd10, 64'd5,  1'b1, 64'd5,  1'b1, 1'b0, 1'b0, 1'b0);
    op("sub_5_10",  64'd5,  64'd10, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0, 1'b0, 1'b0, 1'b1);
    op("pos_ovf",   64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
                    64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
    op("neg_ovf",   64'h8000_0000_0000_0000, 64'd1, 1'b1,
                    64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0);
    op("wrap_add",  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    op("sub_0_0",   64'd0,  64'd0,  1'b1, 64'd0,  1'b1, 1'b0, 1'b1, 1'b0);

    // Reset dominates a simultaneous operation.
    op("pre_rst",   64'd100, 64'd23, 1'b0, 64'd123, 1'b0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    bus.A = 64'd3; bus.B = 64'd4; bus.subtract = 1'b0; bus.in_valid = 1'b1;
    @(negedge clk);
    chk1 ("rst_dom_valid", bus.out_valid, 1'b0);
    chk64("rst_dom_sum",   bus.Sum,       64'd0);
    chk1 ("rst_dom_cout",  bus.Cout,      1'b0);
    chk1 ("rst_dom_ovf",   bus.overflow,  1'b0);
    chk1 ("rst_dom_zero",  bus.zero,      1'b0);
    chk1 ("rst_dom_neg",   bus.negative,  1'b0);
    reset_n = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk1 ("post_rst_idle", bus.out_valid, 1'b0);

    // Hold when idle.
    op("hold_op",   64'd7, 64'd8, 1'b0, 64'd15, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.A = 64'd999; bus.B = 64'd1; bus.subtract = 1'b1;
    @(negedge clk);
    chk1 ("hold_valid", bus.out_valid, 1'b0);
    chk64("hold_sum",   bus.Sum,       64'd15);
    @(negedge clk);
    chk64("hold_sum2",  bus.Sum,       64'd15);

    // Back-to-back: one result per cycle, in order.
    bb_a[0] = 64'd1;   bb_b[0] = 64'd2;  bb_s[0] = 1'b0; bb_e[0] = 64'd3;
    bb_a[1] = 64'd50;  bb_b[1] = 64'd8;  bb_s[1] = 1'b1; bb_e[1] = 64'd42;
    bb_a[2] = 64'd0;   bb_b[2] = 64'd1;  bb_s[2] = 1'b1; bb_e[2] = 64'hFFFF_FFFF_FFFF_FFFF;
    bb_a[3] = 64'h1_0000_0000; bb_b[3] = 64'h1; bb_s[3] = 1'b0; bb_e[3] = 64'h1_0000_0001;
    for (int i = 0; i < 4; i++) begin
      bus.A = bb_a[i]; bus.B = bb_b[i]; bus.subtract = bb_s[i]; bus.in_valid = 1'b1;
      @(negedge clk);
      chk1 ($sformatf("b2b_valid_%0d", i), bus.out_valid, 1'b1);
      chk64($sformatf("b2b_sum_%0d", i),   bus.Sum,       bb_e[i]);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);

    // Additional mixed traffic checked by the reference model.
    for (int i = 0; i < 40; i++) begin
      bus.A = {$urandom, $urandom};
      bus.B = (i % 5 == 0) ? bus.A : {$urandom, $urandom};
      bus.subtract = 1'($urandom_range(0, 1));
      bus.in_valid = (i % 7 != 3);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_subtractor.md
# adder_subtractor

Registered, parameterizable two's-complement adder/subtractor datapath block for the ALU. It computes A+B or A−B through a ripple chain of 1-bit add/subtract cells and registers the result with carry-out, signed overflow and optional zero/negative flags. The ALU result mux and flag logic consume it one cycle after the operands are presented.

## Interface
- WIDTH, 64: operand and result width in bits (≥ 2).
- clk  input  1  sole clock; all state updates on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operands and subtract are captured this cycle.
- A  input  WIDTH  first operand.
- B  input  WIDTH  second operand.
- subtract  input  1  1 = A−B, 0 = A+B.
- out_valid  output  1  registered result valid.
- Sum  output  WIDTH  registered result.
- Cout  output  1  carry out of bit WIDTH−1.
- overflow  output  1  signed overflow.
- zero  output  1  Sum == 0 (flags feature).
- negative  output  1  Sum[WIDTH−1] (flags feature).

## Operation
- Each bit cell: b' = B[i] XOR subtract; Sum[i] = A[i] XOR b' XOR c[i]; c[i+1] = majority(A[i], b', c[i]).
- Chain carry-in c[0] = subtract, so subtract gives A + ~B + 1.
- Cout = c[WIDTH]. For subtract, Cout = 1 means no borrow (A ≥ B unsigned).
- overflow = c[WIDTH] XOR c[WIDTH−1].
- All arithmetic is modulo 2^WIDTH. No saturation.
- in_valid=1: Sum, Cout, overflow, zero and negative load from the combinational result.
- in_valid=0: result registers hold their previous values.
- out_valid is loaded with in_valid every cycle.

## Timing
- Latency is 1 cycle: operands sampled at edge N appear on the outputs after edge N.
- Full throughput: a new operation is accepted every cycle. There is no backpressure.
- Reset (reset_n=0 at a rising edge) clears Sum, Cout, overflow, zero, negative and out_valid to 0.
  - Reset dominates in_valid.
  - An operation captured in the same cycle as reset is discarded.
- After reset deasserts, the first valid result appears one cycle after the first in_valid.
- No combinational path from any input to any output.

## Configuration
- ADDSUB_FLAGS_EN defined: zero and negative are computed and registered as above.
- ADDSUB_FLAGS_EN undefined:
  - zero and negative are driven constant 0.
  - The ports remain so that instantiations are unchanged.
  - Sum, Cout and overflow behaviour is identical in both builds.

## Structure
- Shared package alu_pkg:
  - ADDSUB_WIDTH_DEFAULT = 64.
  - typedef of the flag bundle {Cout, overflow, zero, negative}.
- One sub-module, adder_subtractor_bit: a 1-bit combinational cell.
  - Inputs A, B, Cin, subtract; outputs Cout, Sum.
  - Instantiated WIDTH times in a generate loop, with bit 0's Cin tied to subtract.
- Top level holds the overflow XOR, the zero-detect reduction and the output registers.

## Test plan
All cases use WIDTH=64 and ADDSUB_FLAGS_EN defined; each is checked one cycle after in_valid.
- 0 + 0 -> Sum=0, Cout=0, overflow=0, zero=1, negative=0.
- 10 + 5 -> Sum=15, Cout=0, overflow=0; 10 − 5 -> Sum=5, Cout=1, overflow=0.
- 5 − 10 -> Sum=0xFFFFFFFFFFFFFFFB, Cout=0, overflow=0, negative=1.
- 0x7FFFFFFFFFFFFFFF + 1 -> Sum=0x8000000000000000, overflow=1, Cout=0, negative=1.
- 0x8000000000000000 − 1 -> Sum=0x7FFFFFFFFFFFFFFF, overflow=1, Cout=1.
- Control checks:
  - Drive reset_n=0 with in_valid=1 -> all outputs 0 next cycle.
  - Then in_valid=0 after a valid op -> Sum holds and out_valid=0.
  - Back-to-back ops -> one result per cycle, in order.
